// File: rtl/obc_shift_accumulator.sv
// Bit-serial shift-accumulate stage behind the OBC partial-product ROMs.
// Each accepted slice sums eight ROM words. Slices arrive MSB first, so
// slice 0 carries negative weight. After SAMPLE_W slices, the accumulated
// word plus OFFSET is presented with a one-cycle valid strobe.
// ACC_W must be at least DATA_W + 3 + SAMPLE_W + 1 for the arithmetic not to overflow.
module obc_shift_accumulator #(
  parameter int unsigned             DATA_W   = 32,
  parameter int unsigned             SAMPLE_W = 16,
  parameter int unsigned             ACC_W    = 52,
  parameter logic signed [ACC_W-1:0] OFFSET   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic [DATA_W-1:0] rom0,
  input  logic [DATA_W-1:0] rom1,
  input  logic [DATA_W-1:0] rom2,
  input  logic [DATA_W-1:0] rom3,
  input  logic [DATA_W-1:0] rom4,
  input  logic [DATA_W-1:0] rom5,
  input  logic [DATA_W-1:0] rom6,
  input  logic [DATA_W-1:0] rom7,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy
);

  localparam int unsigned NUM_ROM = 8;
  localparam int unsigned CNT_W   = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLE_W - 1);

  logic [DATA_W-1:0] rom_w [NUM_ROM];
  logic [ACC_W-1:0]  slice_sum;
  logic [CNT_W-1:0]  slice_idx;

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ACC_W-1:0]  s_reg_q, s_reg_d;
  logic              s_valid_q, s_valid_d;
  logic              s_first_q, s_first_d;
  logic              s_last_q, s_last_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic              busy_q, busy_d;

  assign rom_w[0] = rom0;
  assign rom_w[1] = rom1;
  assign rom_w[2] = rom2;
  assign rom_w[3] = rom3;
  assign rom_w[4] = rom4;
  assign rom_w[5] = rom5;
  assign rom_w[6] = rom6;
  assign rom_w[7] = rom7;

  // Sign-extend the eight ROM words to accumulator width and add them.
  always_comb begin
    slice_sum = '0;
    for (int unsigned i = 0; i < NUM_ROM; i++) begin
      slice_sum = slice_sum + ACC_W'($signed(rom_w[i]));
    end
  end

  // Stage 1: slice index tracking and registering of the slice sum.
  always_comb begin
    slice_idx = in_first ? '0 : bit_cnt_q;
    bit_cnt_d = bit_cnt_q;
    s_reg_d   = s_reg_q;
    s_valid_d = 1'b0;
    s_first_d = s_first_q;
    s_last_d  = s_last_q;
    if (in_valid) begin
      s_reg_d   = slice_sum;
      s_valid_d = 1'b1;
      s_first_d = (slice_idx == '0);
      s_last_d  = (slice_idx == LAST_IDX);
      bit_cnt_d = (slice_idx == LAST_IDX) ? '0 : slice_idx + CNT_W'(1);
    end
  end

  // Stage 2: shift-accumulate, final offset, strobe and busy tracking.
  always_comb begin
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    if (s_valid_q) begin
      // The MSB slice restarts the word with negative weight.
      acc_d = s_first_q ? (-s_reg_q) : ((acc_q << 1) + s_reg_q);
      if (s_last_q) begin
        out_valid_d = 1'b1;
        out_data_d  = acc_d + OFFSET;
        busy_d      = 1'b0;
      end
    end
    // A newly accepted slice keeps or makes the stage busy. This also covers
    // the slice 0 of a word that follows the previous word without a gap.
    if (in_valid) begin
      busy_d = 1'b1;
    end
  end

  // State registers with synchronous reset. Reset wins over a slice in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      s_reg_q     <= '0;
      s_valid_q   <= 1'b0;
      s_first_q   <= 1'b0;
      s_last_q    <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      s_reg_q     <= s_reg_d;
      s_valid_q   <= s_valid_d;
      s_first_q   <= s_first_d;
      s_last_q    <= s_last_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_obc_shift_accumulator.sv
// Scoreboard bench for obc_shift_accumulator. It uses two instances that share all inputs:
// one with OFFSET=0 and one with OFFSET=100.
module tb_obc_shift_accumulator;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned ACC_W    = 52;
  localparam longint      OFF1     = 100;

  typedef struct {
    longint data;
    int     cyc;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_first;
  logic [DATA_W-1:0] rom_d [8];
  logic              out_valid0, out_valid1;
  logic [ACC_W-1:0]  out_data0, out_data1;
  logic              busy0, busy1;

  int     vectors     = 0;
  int     miscompares = 0;
  int     cyc         = 0;
  exp_t   q0[$];
  exp_t   q1[$];
  int     m_idx       = 0;
  longint m_acc       = 0;
  logic [DATA_W-1:0] rom_v [8];
  bit     prev_ov     = 1'b0;
  bit     prev_rst    = 1'b1;
  longint last_data0  = 0;

  obc_shift_accumulator #(
    .DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W), .OFFSET(52'sd0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .rom0(rom_d[0]), .rom1(rom_d[1]), .rom2(rom_d[2]), .rom3(rom_d[3]),
    .rom4(rom_d[4]), .rom5(rom_d[5]), .rom6(rom_d[6]), .rom7(rom_d[7]),
    .out_valid(out_valid0), .out_data(out_data0), .busy(busy0)
  );

  obc_shift_accumulator #(
    .DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W), .OFFSET(52'sd100)
  ) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .rom0(rom_d[0]), .rom1(rom_d[1]), .rom2(rom_d[2]), .rom3(rom_d[3]),
    .rom4(rom_d[4]), .rom5(rom_d[5]), .rom6(rom_d[6]), .rom7(rom_d[7]),
    .out_valid(out_valid1), .out_data(out_data1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count one comparison and report it if it does not match.
  task automatic check(input string tag, input longint got, input longint expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  // Drive one slice from rom_v and advance the reference model.
  // Model: word = sum_k S_k * w_k, where w_0 = -2^(SAMPLE_W-1) and w_k = 2^(SAMPLE_W-1-k).
  task automatic apply_slice(input bit first);
    longint s;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_first = first;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      rom_d[i] = rom_v[i];
      s += longint'($signed(rom_v[i]));
    end
    if (first) m_idx = 0;
    if (m_idx == 0) m_acc = -(s * (longint'(1) << (SAMPLE_W - 1)));
    else            m_acc = m_acc + s * (longint'(1) << (SAMPLE_W - 1 - m_idx));
    if (m_idx == SAMPLE_W - 1) begin
      q0.push_back('{m_acc, cyc + 2});
      q1.push_back('{m_acc + OFF1, cyc + 2});
    end
    m_idx = (m_idx == SAMPLE_W - 1) ? 0 : m_idx + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_first = 1'b0;
    end
  endtask

  task automatic set_rand();
    for (int i = 0; i < 8; i++) rom_v[i] = $urandom();
  endtask

  task automatic set_val(input logic [DATA_W-1:0] v0, input logic [DATA_W-1:0] rest);
    rom_v[0] = v0;
    for (int i = 1; i < 8; i++) rom_v[i] = rest;
  endtask

  // Output monitor: strobe pairing, data/latency against the scoreboard, and hold behaviour.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid0 || out_valid1) begin
      check("ov_match", longint'(out_valid1), longint'(out_valid0));
      check("ov_back_to_back", longint'(prev_ov), 0);
      if (q0.size() == 0) check("spurious_strobe0", longint'(q0.size()), 1);
      else begin
        e = q0.pop_front();
        check("data_off0", longint'($signed(out_data0)), e.data);
        check("latency", longint'(cyc), longint'(e.cyc));
      end
      if (q1.size() == 0) check("spurious_strobe1", longint'(q1.size()), 1);
      else begin
        e = q1.pop_front();
        check("data_off100", longint'($signed(out_data1)), e.data);
      end
    end else if (!prev_rst && !rst) begin
      if (longint'($signed(out_data0)) != last_data0)
        check("data_hold", longint'($signed(out_data0)), last_data0);
    end
    prev_ov    = out_valid0;
    prev_rst   = rst;
    last_data0 = longint'($signed(out_data0));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    for (int i = 0; i < 8; i++) begin rom_d[i] = '0; rom_v[i] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid0), 0);
    check("rst_out_data", longint'(out_data0), 0);
    check("rst_busy", longint'(busy0), 0);
    check("rst_busy_off100", longint'(busy1), 0);

    // All ones on every slice: result -8, busy low as the strobe appears.
    set_val(32'd1, 32'd1);
    for (int k = 0; k < SAMPLE_W; k++) begin
      apply_slice(k == 0);
      if (k == 2) begin
        @(negedge clk);
        check("busy_mid_word", longint'(busy0), 1);
      end
    end
    idle(2);
    @(negedge clk);
    check("strobe_at_t_plus_2", longint'(out_valid0), 1);
    check("busy_at_strobe", longint'(busy0), 0);
    idle(2);

    // rom0=1 on the last slice only; slice 0 found via counter wrap (no in_first).
    for (int k = 0; k < SAMPLE_W; k++) begin
      if (k == SAMPLE_W - 1) set_val(32'd1, 32'd0); else set_val(32'd0, 32'd0);
      apply_slice(1'b0);
    end
    idle(3);

    // rom0=1 on slice 0 only: -32768.
    for (int k = 0; k < SAMPLE_W; k++) begin
      if (k == 0) set_val(32'd1, 32'd0); else set_val(32'd0, 32'd0);
      apply_slice(k == 0);
    end
    idle(3);

    // Most negative ROM word on slice 0: 2^46 (2^46 + 100 on the offset instance).
    for (int k = 0; k < SAMPLE_W; k++) begin
      if (k == 0) set_val(32'h8000_0000, 32'd0); else set_val(32'd0, 32'd0);
      apply_slice(k == 0);
    end
    idle(3);

    // Back-to-back random words, 3-cycle gap in the middle of the second.
    for (int k = 0; k < SAMPLE_W; k++) begin set_rand(); apply_slice(k == 0); end
    for (int k = 0; k < SAMPLE_W; k++) begin
      if (k == 8) idle(3);
      set_rand();
      apply_slice(k == 0);
    end
    idle(4);

    // Resync: in_first at slice 5 abandons the partial word.
    for (int k = 0; k < 5; k++) begin set_rand(); apply_slice(k == 0); end
    for (int k = 0; k < SAMPLE_W; k++) begin set_rand(); apply_slice(k == 0); end
    idle(4);

    // Reset at slice 9, with a slice presented in the same cycle.
    for (int k = 0; k < 9; k++) begin set_rand(); apply_slice(k == 0); end
    @(posedge clk); #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_first = 1'b0;
    for (int i = 0; i < 8; i++) rom_d[i] = $urandom();
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    m_idx    = 0;
    @(negedge clk);
    check("post_rst_out_valid", longint'(out_valid0), 0);
    check("post_rst_out_data", longint'(out_data0), 0);
    check("post_rst_out_data_off100", longint'(out_data1), 0);
    check("post_rst_busy", longint'(busy0), 0);
    idle(3);

    // Fresh word after reset, slice 0 identified by the reset count.
    for (int k = 0; k < SAMPLE_W; k++) begin set_rand(); apply_slice(1'b0); end
    idle(5);

    check("pending_off0", longint'(q0.size()), 0);
    check("pending_off100", longint'(q1.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
